stream_downsizer: RTL and testbench

Parametrised AXI-stream width down-converter. Each wide input beat of RATIO sub-words is split into narrow OUT_WIDTH output beats. Supports a per-beat valid sub-word count for partial beats, selectable sub-word order, and full-throughput back-to-back operation with true input backpressure, so no internal FIFO is needed. It sits between wide datapath producers and narrow consumers or serialisers.

---
 rtl/stream_downsizer_pkg.sv | 22 ++
 rtl/stream_downsizer.sv | 117 +++++++++++
 tb/tb_stream_downsizer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/stream_downsizer_pkg.sv
// rtl/stream_downsizer_pkg.sv - shared types and count clamping for stream_downsizer
package stream_downsizer_pkg;

  typedef enum logic {
    IDLE,
    DRAIN
  } downsizer_state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] count;
  } clamp_result_t;

  // Zero or over-range counts become a full beat and raise the error flag.
  function automatic clamp_result_t clamp_count(input logic [31:0] cnt, input logic [31:0] ratio);
    clamp_result_t r;
    r.err   = (cnt == 32'd0) || (cnt > ratio);
    r.count = r.err ? ratio : cnt;
    return r;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// rtl/stream_downsizer.sv - splits each wide stream beat into RATIO narrow beats
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = $clog2(RATIO + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OUT_WIDTH*RATIO-1:0] s_data,
  input  logic [CNT_W-1:0]           s_count,
  input  logic                       s_last,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [OUT_WIDTH-1:0]       m_data,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       err_count
);

  localparam int IDX_W = $clog2(RATIO);

  downsizer_state_t state_q, state_next;

  logic [OUT_WIDTH*RATIO-1:0] data_q, data_next;
  logic [CNT_W-1:0]           cnt_q, cnt_next;
  logic [IDX_W-1:0]           idx_q, idx_next;
  logic                       last_q, last_next;
  logic                       err_q, err_next;

  logic          last_sub;
  logic          accept;
  logic          xfer;
  logic [IDX_W-1:0] pos;
  clamp_result_t clamp;

  assign last_sub  = (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));
  assign s_ready   = !rst && ((state_q == IDLE) || (last_sub && m_ready));
  assign m_valid   = (state_q == DRAIN);
  assign m_last    = (state_q == DRAIN) && last_sub && last_q;
  assign err_count = err_q;
  assign accept    = s_valid && s_ready;
  assign xfer      = m_valid && m_ready;
  assign clamp     = clamp_count(32'(s_count), 32'(RATIO));

  // Emission order reverses the sub-word position when MSB_FIRST is set.
  always_comb begin
    pos = idx_q;
    if (MSB_FIRST != 0) begin
      pos = IDX_W'(RATIO - 1) - idx_q;
    end
    m_data = '0;
    if (state_q == DRAIN) begin
      m_data = data_q[pos*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    state_next = state_q;
    data_next  = data_q;
    cnt_next   = cnt_q;
    idx_next   = idx_q;
    last_next  = last_q;
    err_next   = err_q;

    case (state_q)
      IDLE: begin
        idx_next = '0;
      end
      DRAIN: begin
        if (xfer) begin
          if (last_sub) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A load on the final transfer of the previous beat keeps DRAIN with no bubble.
    if (accept) begin
      state_next = DRAIN;
      data_next  = s_data;
      cnt_next   = CNT_W'(clamp.count);
      idx_next   = '0;
      last_next  = s_last;
      if (clamp.err) begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      data_q  <= data_next;
      cnt_q   <= cnt_next;
      idx_q   <= idx_next;
      last_q  <= last_next;
      err_q   <= err_next;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// tb/tb_stream_downsizer.sv - directed self-checking bench for stream_downsizer
module tb_stream_downsizer;

  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic [2:0]  s_count;
  logic        s_last;
  logic        s_valid;
  logic        m_ready;

  logic        s_ready, s_ready_msb;
  logic [7:0]  m_data, m_data_msb;
  logic        m_last, m_last_msb;
  logic        m_valid, m_valid_msb;
  logic        err_count, err_count_msb;

  int checks = 0;
  int errors = 0;

  stream_downsizer #(.OUT_WIDTH(8), .RATIO(4), .MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_count(s_count), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .err_count(err_count)
  );

  stream_downsizer #(.OUT_WIDTH(8), .RATIO(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_count(s_count), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready_msb),
    .m_data(m_data_msb), .m_last(m_last_msb), .m_valid(m_valid_msb), .m_ready(m_ready),
    .err_count(err_count_msb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic [2:0] cnt, input logic last);
    s_data  = data;
    s_count = cnt;
    s_last  = last;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  logic [7:0] exp_lsb [4];
  logic [7:0] exp_msb [4];
  logic [7:0] exp_rst [4];

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    s_data  = '0;
    s_count = 3'd4;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    exp_lsb = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_msb = '{8'h44, 8'h33, 8'h22, 8'h11};
    exp_rst = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

    tick();
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;
    #1;
    check("idle_s_ready", s_ready, 1);

    // basic LSB-first and MSB-first in parallel
    send(32'h44332211, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("basic_valid", m_valid, 1);
      check("basic_data", m_data, exp_lsb[i]);
      check("basic_last", m_last, (i == 3));
      check("msb_data", m_data_msb, exp_msb[i]);
      check("msb_last", m_last_msb, (i == 3));
      tick();
    end
    check("basic_idle", m_valid, 0);
    check("msb_idle", m_valid_msb, 0);

    // partial beat
    send(32'hDDCCBBAA, 3'd2, 1'b1);
    check("part_data0", m_data, 8'hAA);
    check("part_last0", m_last, 0);
    tick();
    check("part_data1", m_data, 8'hBB);
    check("part_last1", m_last, 1);
    tick();
    check("part_idle", m_valid, 0);

    // back-to-back beats
    s_data  = 32'h04030201;
    s_count = 3'd4;
    s_last  = 1'b0;
    s_valid = 1'b1;
    tick();
    s_data = 32'h08070605;
    s_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", m_valid, 1);
      check("b2b_data", m_data, 32'(i + 1));
      check("b2b_s_ready", s_ready, ((i % 4) == 3));
      check("b2b_last", m_last, (i == 7));
      tick();
      if (i == 3) s_valid = 1'b0;
    end
    check("b2b_idle", m_valid, 0);

    // backpressure on the second sub-word
    send(32'h44332211, 3'd4, 1'b1);
    check("bp_data0", m_data, 8'h11);
    tick();
    m_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", m_data, 8'h22);
      check("bp_hold_valid", m_valid, 1);
      check("bp_hold_s_ready", s_ready, 0);
      tick();
    end
    m_ready = 1'b1;
    #1;
    check("bp_data1", m_data, 8'h22);
    tick();
    check("bp_data2", m_data, 8'h33);
    tick();
    check("bp_data3", m_data, 8'h44);
    check("bp_last3", m_last, 1);
    tick();
    check("bp_idle", m_valid, 0);

    // illegal count expands to a full beat and sets the sticky flag
    send(32'h04030201, 3'd0, 1'b1);
    check("err_set", err_count, 1);
    for (int i = 0; i < 4; i++) begin
      check("err_data", m_data, 32'(i + 1));
      check("err_last", m_last, (i == 3));
      tick();
    end
    check("err_idle", m_valid, 0);
    check("err_sticky", err_count, 1);

    // reset mid-packet discards the beat and clears the flag
    send(32'h44332211, 3'd4, 1'b1);
    check("mid_data0", m_data, 8'h11);
    tick();
    check("mid_data1", m_data, 8'h22);
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", s_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_m_valid", m_valid, 0);
    check("mid_m_last", m_last, 0);
    check("mid_err", err_count, 0);
    tick();
    check("mid_still_idle", m_valid, 0);
    send(32'h0D0C0B0A, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_data", m_data, exp_rst[i]);
      check("post_rst_last", m_last, (i == 3));
      tick();
    end
    check("post_rst_idle", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
